// File: rtl/dmem_responder.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Data-memory responder with four byte-lane RAMs, active-low lane
//            write enables, a fixed access latency and valid/ready request and
//            response channels. Exactly one transaction in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,  // number of 32-bit words
  parameter int LATENCY     = 2     // accept-to-response cycles, 1..15
) (
  input  logic        clk,
  input  logic        rstd,
  // request channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_wren_n,
  input  logic [31:0] req_wdata,
  // response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  // RAM index width; a single-word RAM still needs one index bit.
  localparam int         c_aw     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // The counter is loaded with LATENCY-1 so the access lands on edge E0+LATENCY.
  localparam logic [3:0] c_lat_m1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [29:0] r_word;
  logic        r_we;
  logic [3:0]  r_wren_n;
  logic [31:0] r_wdata;

  logic        w_accept;
  logic        w_access;
  logic        w_in_range;
  logic [c_aw-1:0] w_idx;
  logic [31:0] w_rd_word;

  // Byte-offset bits carry no information: lane selection lives in wren_n.
  logic        w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = ^req_addr[1:0];

  // Range check uses the full word index so aliasing above the RAM is caught.
  assign w_in_range = ({2'b00, r_word} < 32'(DEPTH_WORDS));
  assign w_idx      = r_word[c_aw-1:0];

  // Next-state and handshake decode.
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    w_accept     = 1'b0;
    w_access     = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept     = 1'b1;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_access     = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register; reset drops any pending transaction.
  always_ff @(posedge clk) begin
    if (rstd) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request capture and wait-cycle countdown.
  always_ff @(posedge clk) begin
    if (rstd) begin
      r_cnt    <= 4'd0;
      r_word   <= 30'd0;
      r_we     <= 1'b0;
      r_wren_n <= 4'hF;
      r_wdata  <= 32'd0;
    end else if (w_accept) begin
      r_cnt    <= c_lat_m1;
      r_word   <= req_addr[31:2];
      r_we     <= req_we;
      r_wren_n <= req_wren_n;
      r_wdata  <= req_wdata;
    end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Response payload, captured on the access edge and held through RESP.
  always_ff @(posedge clk) begin
    if (rstd) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (w_access) begin
      if (!w_in_range) begin
        rsp_rdata <= 32'd0;
        rsp_err   <= 1'b1;
      end else if (r_we) begin
        rsp_rdata <= 32'd0;
        rsp_err   <= 1'b0;
      end else begin
        rsp_rdata <= w_rd_word;
        rsp_err   <= 1'b0;
      end
    end
  end

  // One RAM per byte lane so each lane has an independent write enable.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];

    // Lane write on the access edge; reset at the same edge suppresses it.
    always_ff @(posedge clk) begin
      if (!rstd && w_access && w_in_range && r_we && !r_wren_n[i]) begin
        mem[w_idx] <= r_wdata[8*i +: 8];
      end
    end

    assign w_rd_word[8*i +: 8] = mem[w_idx];
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Self-checking bench for dmem_responder. Four instances with
//            latencies 2, 4, 1 and 15; a per-instance word model produces the
//            expected responses, which are queued at drive time and popped
//            when the response arrives.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int N = 4;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 4;
      2:       return 1;
      default: return 15;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rstd;
  logic        req_valid [N];
  logic        req_ready [N];
  logic [31:0] req_addr  [N];
  logic        req_we    [N];
  logic [3:0]  req_wren_n[N];
  logic [31:0] req_wdata [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [31:0] rsp_rdata [N];
  logic        rsp_err   [N];

  always #5 clk = ~clk;

  int cyc = 0;
  // Free-running edge counter used to measure accept spacing.
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(256),
      .LATENCY    (lat_of(g))
    ) u_dut (
      .clk       (clk),
      .rstd      (rstd),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_addr  (req_addr[g]),
      .req_we    (req_we[g]),
      .req_wren_n(req_wren_n[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl[N][256];
  int          last_acc[N];

  // One transaction on instance k; called and returns at a falling edge.
  task automatic txn(input int k, input logic we, input logic [31:0] addr,
                     input logic [3:0] wn, input logic [31:0] wd,
                     input int hold, input bit chk_gap);
    exp_t e;
    int   n;
    int   acc;
    if (addr[31:10] != 22'd0) begin
      e = '{rdata: 32'h0, err: 1'b1};
    end else if (we) begin
      e = '{rdata: 32'h0, err: 1'b0};
      for (int i = 0; i < 4; i++)
        if (!wn[i]) mdl[k][addr[9:2]][8*i +: 8] = wd[8*i +: 8];
    end else begin
      e = '{rdata: mdl[k][addr[9:2]], err: 1'b0};
    end
    sb.push_back(e);

    req_valid[k]  = 1'b1;
    req_we[k]     = we;
    req_addr[k]   = addr;
    req_wren_n[k] = wn;
    req_wdata[k]  = wd;
    rsp_ready[k]  = (hold == 0);
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", 32'(req_ready[k]), 32'd1);
    @(posedge clk);
    acc = cyc;
    if (chk_gap) check("accept_gap", 32'(acc - last_acc[k]), 32'(lat_of(k) + 2));
    last_acc[k] = acc;
    @(negedge clk);
    req_valid[k] = 1'b0;
    n = 1;
    while (!rsp_valid[k] && n < 64) begin
      check("req_ready_busy", 32'(req_ready[k]), 32'd0);
      @(negedge clk);
      n++;
    end
    check("rsp_valid_seen", 32'(rsp_valid[k]), 32'd1);
    e = sb.pop_front();
    if (!rsp_valid[k]) return;
    check("latency", 32'(n - 1), 32'(lat_of(k)));
    check("rdata", rsp_rdata[k], e.rdata);
    check("err", 32'(rsp_err[k]), 32'(e.err));
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid[k]), 32'd1);
      check("hold_rdata", rsp_rdata[k], e.rdata);
      check("hold_err", 32'(rsp_err[k]), 32'(e.err));
      check("hold_req_ready", 32'(req_ready[k]), 32'd0);
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_req_ready", 32'(req_ready[k]), 32'd1);
    check("post_rsp_valid", 32'(rsp_valid[k]), 32'd0);
  endtask

  // Full-word store on instance k with reset landing on edge E0+d; the store
  // must be dropped, so the model is left untouched.
  task automatic rst_store(input int k, input logic [31:0] addr, input logic [31:0] wd, input int d);
    int n;
    req_valid[k]  = 1'b1;
    req_we[k]     = 1'b1;
    req_addr[k]   = addr;
    req_wren_n[k] = 4'h0;
    req_wdata[k]  = wd;
    rsp_ready[k]  = 1'b1;
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;
    repeat (d - 1) @(negedge clk);
    check("rst_pre_valid", 32'(rsp_valid[k]), 32'd0);
    rstd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rstd = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      check("rst_req_ready", 32'(req_ready[k]), 32'd1);
      @(negedge clk);
    end
  endtask

  // Bounds the run in case a handshake never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rstd = 1'b1;
    for (int k = 0; k < N; k++) begin
      req_valid[k]  = 1'b0;
      req_addr[k]   = 32'd0;
      req_we[k]     = 1'b0;
      req_wren_n[k] = 4'hF;
      req_wdata[k]  = 32'd0;
      rsp_ready[k]  = 1'b1;
      last_acc[k]   = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check("rst_req_ready", 32'(req_ready[k]), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      check("rst_rdata", rsp_rdata[k], 32'd0);
      check("rst_err", 32'(rsp_err[k]), 32'd0);
    end
    rstd = 1'b0;
    @(negedge clk);

    // Latency 2: full word, lane masking, out of range, no-op store, backpressure.
    txn(0, 1'b1, 32'h10,  4'h0,    32'hDEADBEEF, 0, 1'b0);
    txn(0, 1'b0, 32'h10,  4'h0,    32'h0,        0, 1'b0);
    txn(0, 1'b1, 32'h10,  4'h0,    32'h11223344, 0, 1'b0);
    txn(0, 1'b1, 32'h12,  4'b1011, 32'h00AA0000, 0, 1'b0);
    txn(0, 1'b0, 32'h10,  4'hF,    32'h0,        0, 1'b0);
    txn(0, 1'b1, 32'h0,   4'h0,    32'h01020304, 0, 1'b0);
    txn(0, 1'b1, 32'h3FC, 4'h0,    32'hF0E0D0C0, 0, 1'b0);
    txn(0, 1'b1, 32'h400, 4'h0,    32'hFFFFFFFF, 0, 1'b0);
    txn(0, 1'b0, 32'h0,   4'hF,    32'h0,        0, 1'b0);
    txn(0, 1'b0, 32'h3FC, 4'hF,    32'h0,        0, 1'b0);
    txn(0, 1'b0, 32'h400, 4'hF,    32'h0,        0, 1'b0);
    txn(0, 1'b1, 32'h20,  4'h0,    32'h55667788, 0, 1'b0);
    txn(0, 1'b1, 32'h20,  4'hF,    32'h0BADF00D, 0, 1'b0);
    txn(0, 1'b0, 32'h20,  4'hF,    32'h0,        0, 1'b0);
    txn(0, 1'b0, 32'h10,  4'hF,    32'h0,        10, 1'b0);

    // Latency 4: reset mid-wait and reset on the access edge both drop the store.
    txn(1, 1'b1, 32'h20, 4'h0, 32'h13579BDF, 0, 1'b0);
    rst_store(1, 32'h20, 32'hCAFEF00D, 2);
    txn(1, 1'b0, 32'h20, 4'hF, 32'h0, 0, 1'b0);
    rst_store(1, 32'h20, 32'hCAFEF00D, 4);
    txn(1, 1'b0, 32'h20, 4'hF, 32'h0, 0, 1'b0);

    // Latency 1 and 15: back-to-back traffic with rsp_ready held high.
    for (int k = 2; k < N; k++) begin
      txn(k, 1'b1, 32'h40, 4'h0, 32'hAAAA5555, 0, 1'b0);
      txn(k, 1'b0, 32'h40, 4'hF, 32'h0,        0, 1'b1);
      txn(k, 1'b1, 32'h44, 4'b0110, 32'h12345678, 0, 1'b1);
      txn(k, 1'b0, 32'h44, 4'hF, 32'h0,        0, 1'b1);
      txn(k, 1'b0, 32'h40, 4'hF, 32'h0,        0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
